// File: rtl/pcie_sub_pkg.sv
// rtl/pcie_sub_pkg.sv - shared state type and default widths for the pcie_sub request path
package pcie_sub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    DRAIN
  } ArbState_t;

  localparam int PCIE_ADDR_W = 64;
  localparam int PCIE_DATA_W = 128;

endpackage

// File: rtl/pcie_rr_pick.sv
// rtl/pcie_rr_pick.sv - rotating-priority picker, first set request at or above the pointer
module pcie_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // scan from lowest to highest priority so the request nearest the pointer is the last writer
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// rtl/pcie_rq_arbiter.sv - round-robin arbiter sharing the RdRq/WrRq ports between requesters
module pcie_rq_arbiter
  import pcie_sub_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int ADDR_W      = PCIE_ADDR_W,
  parameter  int DATA_W      = PCIE_DATA_W,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ-1:0]        ReqWr,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqWData,
  output logic [NUM_REQ-1:0]        ReqDone,
  output logic                      ReqErr,
  output logic [DATA_W-1:0]         ReqRData,
  output logic                      RdRqValid,
  output logic [ADDR_W-1:0]         RdRqAddr,
  input  logic [DATA_W-1:0]         RdRqData,
  input  logic                      RdRqReady,
  input  logic                      RdRqErr,
  output logic                      WrRqValid,
  output logic [ADDR_W-1:0]         WrRqAddr,
  output logic [DATA_W-1:0]         WrRqData,
  input  logic                      WrRqReady,
  input  logic                      WrRqErr,
  output logic                      Busy,
  output logic [IDX_W-1:0]          GrantId,
  output logic                      TimeoutEvt
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  ArbState_t         state;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W-1:0]  rr_ptr;
  logic [31:0]       wd_cnt;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic              match_ready;
  logic              match_err;

  pcie_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (ReqValid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // the shared latch registers drive both request ports directly, so they hold through WAIT
  assign RdRqAddr = addr_q;
  assign WrRqAddr = addr_q;
  assign WrRqData = wdata_q;

  // completion is only recognised on the port that matches the granted direction
  always_comb begin
    match_ready = wr_q ? WrRqReady : RdRqReady;
    match_err   = wr_q ? WrRqErr   : RdRqErr;
    next_ptr    = (GrantId == IDX_W'(NUM_REQ - 1)) ? '0 : GrantId + IDX_W'(1);
  end

  // arbitration FSM with registered pulse outputs, watchdog and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      ReqDone    <= '0;
      ReqErr     <= 1'b0;
      ReqRData   <= '0;
      RdRqValid  <= 1'b0;
      WrRqValid  <= 1'b0;
      Busy       <= 1'b0;
      GrantId    <= '0;
      TimeoutEvt <= 1'b0;
    end else begin
      ReqDone    <= '0;
      ReqErr     <= 1'b0;
      RdRqValid  <= 1'b0;
      WrRqValid  <= 1'b0;
      TimeoutEvt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            GrantId   <= pick_idx;
            wr_q      <= ReqWr[pick_idx];
            addr_q    <= ReqAddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_q   <= ReqWData[int'(pick_idx)*DATA_W +: DATA_W];
            RdRqValid <= ~ReqWr[pick_idx];
            WrRqValid <= ReqWr[pick_idx];
            Busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (match_ready) begin
            ReqDone[GrantId] <= 1'b1;
            ReqErr           <= match_err;
            ReqRData         <= wr_q ? '0 : RdRqData;
            state            <= DONE;
          end else if (state == ISSUE) begin
            wd_cnt <= '0;
            state  <= WAIT;
          end else if ((TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST)) begin
            ReqDone[GrantId] <= 1'b1;
            ReqErr           <= 1'b1;
            ReqRData         <= '0;
            TimeoutEvt       <= 1'b1;
            state            <= DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        DRAIN: begin
          // the late completion belongs to a transaction already reported as failed
          if (match_ready) begin
            rr_ptr <= next_ptr;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// tb/tb_pcie_rq_arbiter.sv - scoreboard bench for pcie_rq_arbiter
module tb_pcie_rq_arbiter;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int TO = 16;

  typedef struct {
    logic [NR-1:0] done;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    ReqValid;
  logic [NR-1:0]    ReqWr;
  logic [NR*AW-1:0] ReqAddr;
  logic [NR*DW-1:0] ReqWData;
  logic [NR-1:0]    ReqDone;
  logic             ReqErr;
  logic [DW-1:0]    ReqRData;
  logic             RdRqValid;
  logic [AW-1:0]    RdRqAddr;
  logic [DW-1:0]    RdRqData;
  logic             RdRqReady;
  logic             RdRqErr;
  logic             WrRqValid;
  logic [AW-1:0]    WrRqAddr;
  logic [DW-1:0]    WrRqData;
  logic             WrRqReady;
  logic             WrRqErr;
  logic             Busy;
  logic [0:0]       GrantId;
  logic             TimeoutEvt;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  exp_t mon_exp;

  pcie_rq_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqWr(ReqWr), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .ReqDone(ReqDone), .ReqErr(ReqErr), .ReqRData(ReqRData),
    .RdRqValid(RdRqValid), .RdRqAddr(RdRqAddr), .RdRqData(RdRqData),
    .RdRqReady(RdRqReady), .RdRqErr(RdRqErr),
    .WrRqValid(WrRqValid), .WrRqAddr(WrRqAddr), .WrRqData(WrRqData),
    .WrRqReady(WrRqReady), .WrRqErr(WrRqErr),
    .Busy(Busy), .GrantId(GrantId), .TimeoutEvt(TimeoutEvt)
  );

  always #5 clk = ~clk;

  // completion scoreboard: every ReqDone pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (!rst && ReqDone !== '0) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done: got ReqDone=%b ReqErr=%b, expected no completion", ReqDone, ReqErr);
      end else begin
        mon_exp = sb.pop_front();
        if (ReqDone !== mon_exp.done || ReqErr !== mon_exp.err || ReqRData !== mon_exp.rdata) begin
          tests_failed++;
          $display("FAIL completion: got done=%b err=%b rdata=%h, expected done=%b err=%b rdata=%h",
                   ReqDone, ReqErr, ReqRData, mon_exp.done, mon_exp.err, mon_exp.rdata);
        end
      end
    end
  end

  task automatic push_exp(input logic [NR-1:0] done, input logic err, input logic [DW-1:0] rdata);
    exp_t e;
    e.done  = done;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic pulse_ready(input bit wr, input bit err, input logic [DW-1:0] data);
    if (wr) begin
      WrRqReady = 1'b1;
      WrRqErr   = err;
    end else begin
      RdRqReady = 1'b1;
      RdRqErr   = err;
      RdRqData  = data;
    end
    @(negedge clk);
    WrRqReady = 1'b0;
    WrRqErr   = 1'b0;
    RdRqReady = 1'b0;
    RdRqErr   = 1'b0;
    RdRqData  = '0;
  endtask

  task automatic wait_issue(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      if (RdRqValid || WrRqValid) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ReqValid = '0; ReqWr = '0; ReqAddr = '0; ReqWData = '0;
    RdRqData = '0; RdRqReady = 1'b0; RdRqErr = 1'b0; WrRqReady = 1'b0; WrRqErr = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (Busy !== 1'b0 || ReqDone !== '0 || ReqErr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: Busy=%b ReqDone=%b ReqErr=%b, expected all 0", Busy, ReqDone, ReqErr);
    end
    tests_run++;
    if (RdRqValid !== 1'b0 || WrRqValid !== 1'b0 || TimeoutEvt !== 1'b0 || GrantId !== '0) begin
      tests_failed++;
      $display("FAIL reset_pulses: Rd=%b Wr=%b Tmo=%b Gnt=%b, expected all 0", RdRqValid, WrRqValid, TimeoutEvt, GrantId);
    end
    tests_run++;
    if (RdRqAddr !== '0 || WrRqData !== '0 || ReqRData !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: RdRqAddr=%h WrRqData=%h ReqRData=%h, expected 0", RdRqAddr, WrRqData, ReqRData);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_request: Busy=%b, expected 0", Busy);
    end
  endtask

  task automatic test_contention();
    bit seen;
    ReqWr = 2'b10;
    ReqAddr[0 +: AW]   = 64'h100;
    ReqAddr[AW +: AW]  = 64'h200;
    ReqWData[DW +: DW] = 128'hC0DE;
    ReqValid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int eid;
      eid = g % 2;
      wait_issue(seen);
      tests_run++;
      if (!seen || GrantId !== eid[0] || RdRqValid !== (eid == 0) || WrRqValid !== (eid == 1)) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: seen=%b GrantId=%b Rd=%b Wr=%b, expected GrantId=%0d", g, seen, GrantId, RdRqValid, WrRqValid, eid);
      end
      push_exp(NR'(1 << eid), 1'b0, (eid == 0) ? DW'(32'h1000 + g) : '0);
      for (int w = 0; w < 2; w++) begin
        @(negedge clk);
        tests_run++;
        if (RdRqValid !== 1'b0 || WrRqValid !== 1'b0 || Busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL contention_wait_quiet: Rd=%b Wr=%b Busy=%b, expected 0 0 1", RdRqValid, WrRqValid, Busy);
        end
      end
      pulse_ready(eid == 1, 1'b0, DW'(32'h1000 + g));
      if (g == 3) ReqValid = '0;
    end
    @(negedge clk);
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_idle: Busy=%b, expected 0", Busy);
    end
  endtask

  task automatic test_single_read();
    ReqWr = '0;
    ReqAddr[0 +: AW] = 64'h10;
    ReqValid = 2'b01;
    push_exp(2'b01, 1'b0, 128'hAB);
    @(negedge clk);
    tests_run++;
    if (RdRqValid !== 1'b1 || WrRqValid !== 1'b0 || RdRqAddr !== 64'h10 || GrantId !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_read_issue: Rd=%b Wr=%b addr=%h Gnt=%b, expected 1 0 10 0", RdRqValid, WrRqValid, RdRqAddr, GrantId);
    end
    @(negedge clk);
    tests_run++;
    if (RdRqValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_read_pulse_width: RdRqValid=%b, expected 0", RdRqValid);
    end
    @(negedge clk);
    pulse_ready(1'b0, 1'b0, 128'hAB);
    tests_run++;
    if (ReqDone !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_read_latency: ReqDone=%b, expected 01", ReqDone);
    end
    ReqValid = '0;
    @(negedge clk);
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_read_idle: Busy=%b, expected 0", Busy);
    end
  endtask

  task automatic test_write_error();
    bit seen;
    ReqWr = 2'b10;
    ReqAddr[AW +: AW]  = 64'h20;
    ReqWData[DW +: DW] = 128'h5A5A;
    ReqValid = 2'b10;
    push_exp(2'b10, 1'b1, '0);
    wait_issue(seen);
    tests_run++;
    if (!seen || WrRqValid !== 1'b1 || WrRqAddr !== 64'h20 || WrRqData !== 128'h5A5A || GrantId !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_issue: seen=%b Wr=%b addr=%h data=%h Gnt=%b", seen, WrRqValid, WrRqAddr, WrRqData, GrantId);
    end
    ReqWData[DW +: DW] = 128'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (WrRqData !== 128'h5A5A || WrRqAddr !== 64'h20 || WrRqValid !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_stable: data=%h addr=%h Wr=%b, expected 5a5a 20 0", WrRqData, WrRqAddr, WrRqValid);
      end
    end
    pulse_ready(1'b1, 1'b1, '0);
    tests_run++;
    if (ReqDone !== 2'b10 || ReqErr !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_error_done: ReqDone=%b ReqErr=%b, expected 10 1", ReqDone, ReqErr);
    end
    ReqValid = '0;
    @(negedge clk);
  endtask

  task automatic test_ready_edges();
    ReqWr = '0;
    ReqAddr[0 +: AW] = 64'h30;
    ReqValid = 2'b01;
    push_exp(2'b01, 1'b0, 128'h77);
    @(negedge clk);
    tests_run++;
    if (RdRqValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_ready_pulse: RdRqValid=%b, expected 1", RdRqValid);
    end
    pulse_ready(1'b0, 1'b0, 128'h77);
    tests_run++;
    if (ReqDone !== 2'b01) begin
      tests_failed++;
      $display("FAIL ready_in_issue: ReqDone=%b, expected 01", ReqDone);
    end
    ReqValid = '0;
    @(negedge clk);
    ReqAddr[0 +: AW] = 64'h34;
    ReqValid = 2'b01;
    push_exp(2'b01, 1'b0, 128'h88);
    @(negedge clk);
    @(negedge clk);
    pulse_ready(1'b1, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ReqDone !== '0 || Busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrong_port_ignored: ReqDone=%b Busy=%b, expected 00 1", ReqDone, Busy);
      end
      @(negedge clk);
    end
    pulse_ready(1'b0, 1'b0, 128'h88);
    tests_run++;
    if (ReqDone !== 2'b01) begin
      tests_failed++;
      $display("FAIL wrong_port_then_done: ReqDone=%b, expected 01", ReqDone);
    end
    ReqValid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    ReqWr = 2'b10;
    ReqAddr[AW +: AW]  = 64'h60;
    ReqWData[DW +: DW] = 128'h1234;
    ReqValid = 2'b10;
    wait_issue(seen);
    tests_run++;
    if (!seen || GrantId !== 1'b1 || WrRqValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_pre_grant: seen=%b Gnt=%b Wr=%b, expected 1 1 1", seen, GrantId, WrRqValid);
    end
    ReqAddr[0 +: AW] = 64'h70;
    ReqValid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (Busy !== 1'b0 || GrantId !== 1'b0 || WrRqAddr !== '0 || WrRqData !== '0 || ReqDone !== '0 || TimeoutEvt !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: Busy=%b Gnt=%b addr=%h data=%h done=%b, expected all 0", Busy, GrantId, WrRqAddr, WrRqData, ReqDone);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(2'b01, 1'b0, 128'h70AA);
    wait_issue(seen);
    tests_run++;
    if (!seen || GrantId !== 1'b0 || RdRqValid !== 1'b1 || RdRqAddr !== 64'h70) begin
      tests_failed++;
      $display("FAIL reset_ptr_regrant: seen=%b Gnt=%b Rd=%b addr=%h, expected 1 0 1 70", seen, GrantId, RdRqValid, RdRqAddr);
    end
    @(negedge clk);
    pulse_ready(1'b0, 1'b0, 128'h70AA);
    ReqValid = 2'b10;
    push_exp(2'b10, 1'b0, '0);
    wait_issue(seen);
    tests_run++;
    if (!seen || GrantId !== 1'b1 || WrRqValid !== 1'b1 || WrRqData !== 128'h1234) begin
      tests_failed++;
      $display("FAIL reset_second_grant: seen=%b Gnt=%b Wr=%b data=%h, expected 1 1 1 1234", seen, GrantId, WrRqValid, WrRqData);
    end
    pulse_ready(1'b1, 1'b0, '0);
    ReqValid = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen;
    bit quiet;
    ReqWr = '0;
    ReqAddr[0 +: AW] = 64'h40;
    ReqValid = 2'b01;
    push_exp(2'b01, 1'b1, '0);
    @(negedge clk);
    tests_run++;
    if (RdRqValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_issue: RdRqValid=%b, expected 1", RdRqValid);
    end
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      tests_run++;
      if (ReqDone !== '0 || TimeoutEvt !== 1'b0 || Busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_early wait%0d: ReqDone=%b Tmo=%b Busy=%b, expected 00 0 1", i, ReqDone, TimeoutEvt, Busy);
      end
    end
    @(negedge clk);
    tests_run++;
    if (TimeoutEvt !== 1'b1 || ReqDone !== 2'b01 || ReqErr !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_expiry: Tmo=%b ReqDone=%b ReqErr=%b, expected 1 01 1", TimeoutEvt, ReqDone, ReqErr);
    end
    ReqWr = 2'b10;
    ReqAddr[AW +: AW]  = 64'h80;
    ReqWData[DW +: DW] = 128'hBEEF;
    ReqValid = 2'b10;
    @(negedge clk);
    tests_run++;
    if (TimeoutEvt !== 1'b0 || Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_drain_state: Tmo=%b Busy=%b, expected 0 1", TimeoutEvt, Busy);
    end
    quiet = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (RdRqValid || WrRqValid || !Busy) quiet = 1'b0;
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_no_grant: quiet=%b, expected 1", quiet);
    end
    pulse_ready(1'b0, 1'b0, 128'hDEAD);
    tests_run++;
    if (ReqDone !== '0) begin
      tests_failed++;
      $display("FAIL drain_absorb: ReqDone=%b, expected 00", ReqDone);
    end
    push_exp(2'b10, 1'b0, '0);
    wait_issue(seen);
    tests_run++;
    if (!seen || GrantId !== 1'b1 || WrRqValid !== 1'b1 || WrRqAddr !== 64'h80) begin
      tests_failed++;
      $display("FAIL after_drain_grant: seen=%b Gnt=%b Wr=%b addr=%h, expected 1 1 1 80", seen, GrantId, WrRqValid, WrRqAddr);
    end
    pulse_ready(1'b1, 1'b0, '0);
    ReqValid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_write_error();
    test_ready_edges();
    test_reset_mid();
    test_timeout();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drained: %0d completions outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
